// File: rtl/bmu_req_arb_if.sv
// Signal bundle around bmu_req_arb: two requesters, the BMU issue/result path and the response port.
// The arbiter connects through the slave modport; the surrounding environment uses master.
interface bmu_req_arb_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][21:0] req_ap;
    logic             bmu_valid_in;
    logic [31:0]      bmu_a;
    logic [31:0]      bmu_b;
    logic [21:0]      bmu_ap;
    logic [31:0]      bmu_result;
    logic             bmu_error;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [31:0]      rsp_data;
    logic             rsp_error;

    modport slave (
        input  req_valid, req_a, req_b, req_ap, bmu_result, bmu_error, rsp_ready,
        output req_ready, bmu_valid_in, bmu_a, bmu_b, bmu_ap, rsp_valid, rsp_id, rsp_data, rsp_error
    );

    modport master (
        output req_valid, req_a, req_b, req_ap, bmu_result, bmu_error, rsp_ready,
        input  req_ready, bmu_valid_in, bmu_a, bmu_b, bmu_ap, rsp_valid, rsp_id, rsp_data, rsp_error
    );
endinterface

// File: rtl/bmu_req_arb.sv
// Two-port request arbiter in front of the BMU: grants one requester, issues one op, returns its result.
// Build option BMU_ARB_RR_EN: round-robin on contention; without it port 0 has fixed priority.
module bmu_req_arb (
    input  logic         clk,
    input  logic         rst_l,
    bmu_req_arb_if.slave io_bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        w_do_grant;
    logic        w_grant_id;
    logic [21:0] w_grant_ap;
    logic        w_grant_legal;

    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [21:0] r_op_ap;
    logic        r_rsp_id;
    logic [31:0] r_rsp_data;
    logic        r_rsp_error;

    logic [1:0]  w_req_ready;
    logic        w_bmu_valid;
    logic [31:0] w_bmu_a;
    logic [31:0] w_bmu_b;
    logic [21:0] w_bmu_ap;
    logic        w_rsp_valid;

    function automatic logic is_one_hot(input logic [21:0] vec);
        return (vec != 22'd0) && ((vec & (vec - 22'd1)) == 22'd0);
    endfunction

`ifdef BMU_ARB_RR_EN
    logic r_rr_prio;

    // Contention goes to the favoured port; a lone requester always wins.
    always_comb begin
        if (io_bus.req_valid == 2'b11) begin
            w_grant_id = r_rr_prio;
        end else begin
            w_grant_id = io_bus.req_valid[1] & ~io_bus.req_valid[0];
        end
    end

    // Favour the port that was not granted most recently; port 0 after reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rr_prio <= 1'b0;
        end else if (w_do_grant) begin
            r_rr_prio <= ~w_grant_id;
        end
    end
`else
    // Port 0 wins whenever it requests.
    always_comb begin
        w_grant_id = io_bus.req_valid[1] & ~io_bus.req_valid[0];
    end
`endif

    // Grant only from IDLE; gated by rst_l so req_ready stays low while reset is held.
    assign w_do_grant    = rst_l & (r_state == ST_IDLE) & (|io_bus.req_valid);
    assign w_grant_ap    = io_bus.req_ap[w_grant_id];
    assign w_grant_legal = is_one_hot(w_grant_ap);

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a malformed control vector skips the BMU and answers with an error.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_do_grant) begin
                    w_next_state = w_grant_legal ? ST_ISSUE : ST_RESP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE:   w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_RESP;
            ST_RESP: begin
                if (io_bus.rsp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Operand and response holding registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_op_a      <= 32'd0;
            r_op_b      <= 32'd0;
            r_op_ap     <= 22'd0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_error <= 1'b0;
        end else if (w_do_grant) begin
            r_op_a   <= io_bus.req_a[w_grant_id];
            r_op_b   <= io_bus.req_b[w_grant_id];
            r_op_ap  <= w_grant_ap;
            r_rsp_id <= w_grant_id;
            if (!w_grant_legal) begin
                r_rsp_data  <= 32'd0;
                r_rsp_error <= 1'b1;
            end
        end else if (r_state == ST_CAPTURE) begin
            // The BMU result is only valid during this one cycle.
            r_rsp_data  <= io_bus.bmu_result;
            r_rsp_error <= io_bus.bmu_error;
        end
    end

    // Output decode: handshake, BMU issue bus and response valid.
    always_comb begin
        w_req_ready = 2'b00;
        w_bmu_valid = 1'b0;
        w_bmu_a     = 32'd0;
        w_bmu_b     = 32'd0;
        w_bmu_ap    = 22'd0;
        w_rsp_valid = 1'b0;
        if (w_do_grant) begin
            w_req_ready = w_grant_id ? 2'b10 : 2'b01;
        end else begin
            w_req_ready = 2'b00;
        end
        if (r_state == ST_ISSUE) begin
            w_bmu_valid = 1'b1;
            w_bmu_a     = r_op_a;
            w_bmu_b     = r_op_b;
            w_bmu_ap    = r_op_ap;
        end else begin
            w_bmu_valid = 1'b0;
            w_bmu_a     = 32'd0;
            w_bmu_b     = 32'd0;
            w_bmu_ap    = 22'd0;
        end
        if (r_state == ST_RESP) begin
            w_rsp_valid = 1'b1;
        end else begin
            w_rsp_valid = 1'b0;
        end
    end

    assign io_bus.req_ready    = w_req_ready;
    assign io_bus.bmu_valid_in = w_bmu_valid;
    assign io_bus.bmu_a        = w_bmu_a;
    assign io_bus.bmu_b        = w_bmu_b;
    assign io_bus.bmu_ap       = w_bmu_ap;
    assign io_bus.rsp_valid    = w_rsp_valid;
    assign io_bus.rsp_id       = r_rsp_id;
    assign io_bus.rsp_data     = r_rsp_data;
    assign io_bus.rsp_error    = r_rsp_error;

endmodule

// File: tb/tb_bmu_req_arb.sv
// Self-checking bench for bmu_req_arb: vector table, hand-written stall/reset sequences, random traffic.
`timescale 1ns/1ps
module tb_bmu_req_arb;

    localparam int AP_LAND = 0;
    localparam int AP_LOR  = 1;
    localparam int AP_LXOR = 2;
    localparam int AP_ADD  = 10;
    localparam int AP_SUB  = 11;
    localparam logic [21:0] OP_LAND = 22'h000001;
    localparam logic [21:0] OP_LOR  = 22'h000002;
    localparam logic [21:0] OP_LXOR = 22'h000004;
    localparam logic [21:0] OP_ADD  = 22'h000400;
    localparam logic [21:0] OP_SUB  = 22'h000800;

`ifdef BMU_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, b0;
        logic [21:0] ap0;
        logic [31:0] a1, b1;
        logic [21:0] ap1;
        logic        exp_id;
        logic        exp_issue;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic rst_l;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[9];

    bmu_req_arb_if bus ();
    bmu_req_arb dut (.clk(clk), .rst_l(rst_l), .io_bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaviour of the handful of BMU operations the bench uses; error flags signed overflow.
    function automatic logic [32:0] bmu_fn(input logic [31:0] a, input logic [31:0] b, input logic [21:0] ap);
        logic [31:0] r;
        logic        e;
        r = 32'd0;
        e = 1'b0;
        if (ap[AP_LAND])      r = a & b;
        else if (ap[AP_LOR])  r = a | b;
        else if (ap[AP_LXOR]) r = a ^ b;
        else if (ap[AP_ADD]) begin r = a + b; e = (a[31] == b[31]) && (r[31] != a[31]); end
        else if (ap[AP_SUB]) begin r = a - b; e = (a[31] != b[31]) && (r[31] != a[31]); end
        else r = 32'd0;
        return {e, r};
    endfunction

    // BMU stand-in: registered result in the cycle after issue, junk in every other cycle.
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            bus.bmu_result <= 32'd0;
            bus.bmu_error  <= 1'b0;
        end else if (bus.bmu_valid_in) begin
            {bus.bmu_error, bus.bmu_result} <= bmu_fn(bus.bmu_a, bus.bmu_b, bus.bmu_ap);
        end else begin
            bus.bmu_result <= 32'hDEAD_BEEF;
            bus.bmu_error  <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [123:0] all_outs();
        return {bus.req_ready, bus.bmu_valid_in, bus.bmu_a, bus.bmu_b, bus.bmu_ap,
                bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_error};
    endfunction

    function automatic vec_t mk(input logic [1:0] valid,
                                input logic [31:0] a0, input logic [31:0] b0, input logic [21:0] ap0,
                                input logic [31:0] a1, input logic [31:0] b1, input logic [21:0] ap1,
                                input logic id, input logic issue, input logic [31:0] data, input logic err);
        vec_t v;
        v.valid = valid; v.a0 = a0; v.b0 = b0; v.ap0 = ap0; v.a1 = a1; v.b1 = b1; v.ap1 = ap1;
        v.exp_id = id; v.exp_issue = issue; v.exp_data = data; v.exp_err = err;
        return v;
    endfunction

    function automatic logic [21:0] rand_ap();
        int i;
        int j;
        i = $urandom_range(0, 21);
        j = (i + 1 + $urandom_range(0, 20)) % 22;
        case ($urandom_range(0, 9))
            0:       return 22'd0;
            1:       return (22'd1 << i) | (22'd1 << j);
            2:       return 22'($urandom());
            3, 4:    return 22'd1 << i;
            5:       return OP_LAND;
            6:       return OP_LXOR;
            7:       return OP_SUB;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        if ($urandom_range(0, 3) == 0) return 32'h7FFF_FFFF;
        else return $urandom();
    endfunction

    // One table vector from IDLE: grant, issue slot, response slot and contents.
    task automatic run_vec(input int idx, input vec_t v);
        int          t_issue;
        int          t_rsp;
        int          n_issue;
        logic [85:0] got_bmu;
        logic [33:0] got_rsp;
        @(negedge clk);
        bus.req_valid = v.valid;
        bus.req_a[0] = v.a0; bus.req_b[0] = v.b0; bus.req_ap[0] = v.ap0;
        bus.req_a[1] = v.a1; bus.req_b[1] = v.b1; bus.req_ap[1] = v.ap1;
        bus.rsp_ready = 1'b1;
        #1;
        check($sformatf("vec%0d req_ready", idx), bus.req_ready, v.exp_id ? 2'b10 : 2'b01);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.req_a[0] = $urandom(); bus.req_b[0] = $urandom(); bus.req_ap[0] = 22'($urandom());
        bus.req_a[1] = $urandom(); bus.req_b[1] = $urandom(); bus.req_ap[1] = 22'($urandom());
        t_issue = -1; t_rsp = -1; n_issue = 0; got_bmu = '0; got_rsp = '0;
        for (int t = 0; t < 8; t++) begin
            if (bus.bmu_valid_in) begin
                n_issue++;
                t_issue = t;
                got_bmu = {bus.bmu_a, bus.bmu_b, bus.bmu_ap};
            end
            if (bus.rsp_valid && t_rsp < 0) begin
                t_rsp = t;
                got_rsp = {bus.rsp_id, bus.rsp_data, bus.rsp_error};
            end
            @(negedge clk);
        end
        check($sformatf("vec%0d timing", idx), {8'(n_issue), 8'(t_issue), 8'(t_rsp)},
              v.exp_issue ? {8'd1, 8'd0, 8'd2} : {8'd0, 8'hFF, 8'd0});
        check($sformatf("vec%0d bmu_ops", idx), got_bmu,
              !v.exp_issue ? 86'd0 : (v.exp_id ? {v.a1, v.b1, v.ap1} : {v.a0, v.b0, v.ap0}));
        check($sformatf("vec%0d rsp", idx), got_rsp, {v.exp_id, v.exp_data, v.exp_err});
    endtask

    // Random traffic against a transaction-timeline model of the arbiter.
    task automatic run_random(input int n_cycles);
        bit          busy;
        int          hs;
        logic        last_g, g;
        logic        e_legal, e_id, e_err;
        logic [31:0] e_a, e_b, e_data;
        logic [21:0] e_ap;
        logic        exp_issue, exp_rv;
        logic [1:0]  exp_ready;
        busy = 1'b0; hs = 0; last_g = 1'b1; g = 1'b0;
        e_legal = 1'b0; e_id = 1'b0; e_err = 1'b0; e_a = '0; e_b = '0; e_data = '0; e_ap = '0;
        for (int k = 0; k < n_cycles; k++) begin
            exp_issue = busy && e_legal && (k == hs);
            exp_rv    = busy && (k >= (e_legal ? hs + 2 : hs));
            check($sformatf("rnd%0d bmu", k), {bus.bmu_valid_in, bus.bmu_a, bus.bmu_b, bus.bmu_ap},
                  exp_issue ? {1'b1, e_a, e_b, e_ap} : 87'd0);
            check($sformatf("rnd%0d rsp_valid", k), bus.rsp_valid, exp_rv);
            if (exp_rv)
                check($sformatf("rnd%0d rsp", k), {bus.rsp_id, bus.rsp_data, bus.rsp_error}, {e_id, e_data, e_err});
            bus.req_valid = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                bus.req_a[p] = rand_opnd(); bus.req_b[p] = rand_opnd(); bus.req_ap[p] = rand_ap();
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.req_valid == 2'b11) g = RR_MODE ? ~last_g : 1'b0;
            else g = bus.req_valid[1];
            exp_ready = (!busy && bus.req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
            check($sformatf("rnd%0d req_ready", k), bus.req_ready, exp_ready);
            if (!busy && bus.req_valid != 2'b00) begin
                busy = 1'b1; hs = k + 1; last_g = g; e_id = g;
                e_a = bus.req_a[g]; e_b = bus.req_b[g]; e_ap = bus.req_ap[g];
                e_legal = ($countones(e_ap) == 1);
                {e_err, e_data} = e_legal ? bmu_fn(e_a, e_b, e_ap) : {1'b1, 32'd0};
            end else if (exp_rv && bus.rsp_ready) begin
                busy = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.req_valid = 2'b00; bus.req_a = '0; bus.req_b = '0; bus.req_ap = '0;
        bus.rsp_ready = 1'b0;
        rst_l = 1'b0;

        @(negedge clk);
        bus.req_valid = 2'b11; bus.req_ap[0] = OP_ADD; bus.req_ap[1] = OP_ADD;
        #1;
        check("reset outputs", all_outs(), 124'd0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst_l = 1'b1;
        #1;
        check("post-reset idle", all_outs(), 124'd0);

        vecs[0] = mk(2'b11, 32'hF0F0_00FF, 32'hFF00_0F0F, OP_LAND, 32'h1234_5678, 32'h0F0F_0F0F, OP_LXOR,
                     1'b0, 1'b1, 32'hF000_000F, 1'b0);
        vecs[1] = mk(2'b11, 32'hF0F0_00FF, 32'hFF00_0F0F, OP_LAND, 32'h1234_5678, 32'h0F0F_0F0F, OP_LXOR,
                     RR_MODE, 1'b1, RR_MODE ? 32'h1D3B_5977 : 32'hF000_000F, 1'b0);
        vecs[2] = vecs[0];
        vecs[3] = vecs[1];
        vecs[4] = mk(2'b01, 32'd5, 32'd7, OP_ADD, 32'h1111_1111, 32'h2222_2222, OP_SUB,
                     1'b0, 1'b1, 32'd12, 1'b0);
        vecs[5] = mk(2'b10, 32'd9, 32'd9, OP_LOR, 32'h7FFF_FFFF, 32'd1, OP_ADD,
                     1'b1, 1'b1, 32'h8000_0000, 1'b1);
        vecs[6] = mk(2'b01, 32'd5, 32'd7, OP_ADD | OP_SUB, 32'd0, 32'd0, OP_ADD,
                     1'b0, 1'b0, 32'd0, 1'b1);
        vecs[7] = mk(2'b01, 32'd5, 32'd7, OP_SUB, 32'd3, 32'd4, OP_ADD,
                     1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        vecs[8] = mk(2'b11, 32'h0000_00F0, 32'h0000_0F00, OP_LOR, 32'h8000_0000, 32'd1, OP_SUB,
                     RR_MODE, 1'b1, RR_MODE ? 32'h7FFF_FFFF : 32'h0000_0FF0, RR_MODE);
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Response back-pressure: fields hold and no new grant while rsp_ready is low.
        @(negedge clk);
        bus.req_valid = 2'b01; bus.req_a[0] = 32'd100; bus.req_b[0] = 32'd23; bus.req_ap[0] = OP_ADD;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = 2'b11; bus.req_ap[1] = OP_LAND;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall%0d", i), {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_error, bus.req_ready},
                  {1'b1, 1'b0, 32'd123, 1'b0, 2'b00});
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        bus.req_valid = 2'b10;
        #1;
        check("stall release idle", {bus.rsp_valid, bus.req_ready}, {1'b0, 2'b10});
        bus.req_valid = 2'b00;

        // Reset while the op sits in CAPTURE: everything drops at once and the op is lost.
        @(negedge clk);
        bus.req_valid = 2'b01; bus.req_a[0] = 32'd1; bus.req_b[0] = 32'd2; bus.req_ap[0] = OP_ADD;
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        bus.req_valid = 2'b11;
        #2 rst_l = 1'b0;
        #1;
        check("reset in capture", all_outs(), 124'd0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst_l = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("after reset %0d", i), {bus.rsp_valid, bus.bmu_valid_in, bus.req_ready}, 4'd0);
            @(negedge clk);
        end
        bus.req_valid = 2'b11;
        #1;
        check("pointer after reset", bus.req_ready, 2'b01);
        bus.req_valid = 2'b00;

        run_random(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
